// File: rtl/div_dispatch.sv
// Divide front-end: resolves zero-divisor, signed overflow and cache hits in zero cycles,
// otherwise holds registered operands for the iterative divider core until it completes.
package types;
  typedef enum logic [1:0] {divop_div, divop_divu, divop_rem, divop_remu} rv32_divop;
endpackage

module div_dispatch
  import types::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  rv32_divop    i_divop,
  input  logic [N-1:0] i_data_n,
  input  logic [N-1:0] i_data_d,
  output logic [N-1:0] o_data,
  output logic         o_stall,
  output logic         o_div_en,
  output rv32_divop    o_div_divop,
  output logic [N-1:0] o_div_data_n,
  output logic [N-1:0] o_div_data_d,
  input  logic [N-1:0] i_div_data,
  input  logic         i_div_stall
);

  localparam logic [N-1:0] MinNeg = {1'b1, {(N-1){1'b0}}};

  typedef enum logic {StIdle, StBusy} state_e;

  state_e       state_q, state_d;
  logic         seen_busy_q, seen_busy_d;
  logic         capture, cache_we;
  rv32_divop    op_q;
  logic [N-1:0] n_q, d_q;

  logic         c_valid_q, c_signed_q, c_q_valid_q, c_r_valid_q;
  logic [N-1:0] c_n_q, c_d_q, c_q_q, c_r_q;

  logic req_signed, req_quot, is_zero, is_ovf, is_hit, bypass, core_done;
  logic wr_signed, wr_quot, wr_same;

  assign req_signed = (i_divop == divop_div) || (i_divop == divop_rem);
  assign req_quot   = (i_divop == divop_div) || (i_divop == divop_divu);
  assign is_zero    = (i_data_d == '0);
  assign is_ovf     = req_signed && (i_data_n == MinNeg) && (i_data_d == '1);
  assign is_hit     = c_valid_q && (c_signed_q == req_signed) && (c_n_q == i_data_n) &&
                      (c_d_q == i_data_d) && (req_quot ? c_q_valid_q : c_r_valid_q);
  assign bypass     = i_en && (is_zero || is_ovf || is_hit);

  // The core's first non-stall cycle only counts once it has actually been busy.
  assign core_done  = (state_q == StBusy) && i_en && !bypass && seen_busy_q && !i_div_stall;

  assign wr_signed  = (op_q == divop_div) || (op_q == divop_rem);
  assign wr_quot    = (op_q == divop_div) || (op_q == divop_divu);
  assign wr_same    = c_valid_q && (c_signed_q == wr_signed) && (c_n_q == n_q) && (c_d_q == d_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      seen_busy_q <= 1'b0;
      op_q        <= divop_div;
      n_q         <= '0;
      d_q         <= '0;
      c_valid_q   <= 1'b0;
      c_signed_q  <= 1'b0;
      c_q_valid_q <= 1'b0;
      c_r_valid_q <= 1'b0;
      c_n_q       <= '0;
      c_d_q       <= '0;
      c_q_q       <= '0;
      c_r_q       <= '0;
    end else begin
      state_q     <= state_d;
      seen_busy_q <= seen_busy_d;
      if (capture) begin
        op_q <= i_divop;
        n_q  <= i_data_n;
        d_q  <= i_data_d;
      end
      if (cache_we) begin
        if (!wr_same) begin
          c_valid_q  <= 1'b1;
          c_signed_q <= wr_signed;
          c_n_q      <= n_q;
          c_d_q      <= d_q;
        end
        if (wr_quot) begin
          c_q_valid_q <= 1'b1;
          c_q_q       <= i_div_data;
          if (!wr_same) c_r_valid_q <= 1'b0;
        end else begin
          c_r_valid_q <= 1'b1;
          c_r_q       <= i_div_data;
          if (!wr_same) c_q_valid_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    seen_busy_d = seen_busy_q;
    capture     = 1'b0;
    cache_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_en && !bypass) begin
          state_d     = StBusy;
          capture     = 1'b1;
          seen_busy_d = 1'b0;
        end
      end
      StBusy: begin
        if (!i_en || bypass) begin
          state_d = StIdle;
        end else if (core_done) begin
          state_d  = StIdle;
          cache_we = 1'b1;
        end else if (i_div_stall) begin
          seen_busy_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    o_data   = '0;
    o_stall  = i_en && !bypass && !core_done;
    o_div_en = (state_q == StBusy) && i_en && !bypass && !i_rst;
    if (i_en) begin
      if (is_zero)     o_data = req_quot ? '1 : i_data_n;
      else if (is_ovf) o_data = req_quot ? i_data_n : '0;
      else if (is_hit) o_data = req_quot ? c_q_q : c_r_q;
      else if (core_done) o_data = i_div_data;
    end
  end

  assign o_div_divop  = op_q;
  assign o_div_data_n = n_q;
  assign o_div_data_d = d_q;

endmodule

// File: tb/tb_div_dispatch.sv
// Scoreboard bench for div_dispatch with a behavioural iterative divider core.
module tb_div_dispatch;
  import types::*;

  logic        clk = 1'b0;
  logic        rst, en;
  rv32_divop   divop;
  logic [31:0] dn, dd, data;
  logic        stall, div_en;
  rv32_divop   div_op;
  logic [31:0] div_n, div_d, div_data;
  logic        div_stall;

  int n_checks = 0;
  int n_pass   = 0;
  int core_lat = 3;
  int cnt      = 0;

  logic [31:0] expq[$];
  string       nameq[$];

  always #5 clk = ~clk;

  div_dispatch #(.N(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_divop     (divop),
    .i_data_n    (dn),
    .i_data_d    (dd),
    .o_data      (data),
    .o_stall     (stall),
    .o_div_en    (div_en),
    .o_div_divop (div_op),
    .o_div_data_n(div_n),
    .o_div_data_d(div_d),
    .i_div_data  (div_data),
    .i_div_stall (div_stall)
  );

  // RISC-V M-extension reference semantics.
  function automatic logic [31:0] golden(rv32_divop op, logic [31:0] n, logic [31:0] d);
    logic s, q;
    s = (op == divop_div) || (op == divop_rem);
    q = (op == divop_div) || (op == divop_divu);
    if (d == 32'd0) return q ? 32'hFFFF_FFFF : n;
    if (s && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) return q ? n : 32'd0;
    if (s) return q ? 32'($signed(n) / $signed(d)) : 32'($signed(n) % $signed(d));
    return q ? n / d : n % d;
  endfunction

  // Core model: busy for core_lat enabled cycles, then presents the result.
  always_ff @(posedge clk) begin
    if (!div_en) cnt <= 0;
    else         cnt <= cnt + 1;
  end
  assign div_stall = div_en && (cnt < core_lat);
  assign div_data  = golden(div_op, div_n, div_d);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on each accepted result, watches o_div_* stability.
  rv32_divop   sv_op;
  logic [31:0] sv_n, sv_d;
  bit          in_busy = 1'b0;
  always @(negedge clk) begin
    if (!rst && en && !stall) begin
      if (expq.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
      else chk(nameq.pop_front(), data, expq.pop_front());
    end
    if (!en) chk("idle_data_zero", data, 32'd0);
    if (div_en) begin
      if (in_busy) chk("div_ops_stable", 32'(div_n !== sv_n || div_d !== sv_d || div_op !== sv_op), 32'd0);
      sv_op = div_op; sv_n = div_n; sv_d = div_d;
      in_busy = 1'b1;
    end else begin
      in_busy = 1'b0;
    end
  end

  // Drive a request and hold it until accepted; exp_stall < 0 skips the latency check.
  task automatic issue(input string name, input rv32_divop op, input logic [31:0] n,
                       input logic [31:0] d, input logic [31:0] exp, input int exp_stall);
    int stalls = 0;
    int den    = 0;
    bit done   = 1'b0;
    en = 1'b1; divop = op; dn = n; dd = d;
    expq.push_back(exp);
    nameq.push_back(name);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (div_en) den++;
      if (!stall) done = 1'b1;
      else stalls++;
    end
    if (!done) begin
      chk({name, "_timeout"}, 32'd1, 32'd0);
      void'(expq.pop_back());
      void'(nameq.pop_back());
    end
    if (exp_stall >= 0) begin
      chk({name, "_stall"}, 32'(stalls), 32'(exp_stall));
      if (exp_stall == 0) chk({name, "_div_en"}, 32'(den), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    en = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; divop = divop_divu; dn = 32'd100; dd = 32'd7;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_div_en", 32'(div_en), 32'd0);
    chk("rst_div_n", div_n, 32'd0);
    chk("rst_div_d", div_d, 32'd0);
    @(posedge clk); #1;

    // Cold miss, other-kind miss on same operands, then a hit.
    issue("divu_100_7", divop_divu, 32'd100, 32'd7, 32'd14, 4);
    issue("remu_100_7", divop_remu, 32'd100, 32'd7, 32'd2, 4);
    issue("divu_100_7_hit", divop_divu, 32'd100, 32'd7, 32'd14, 0);
    idle();

    issue("div_ovf", divop_div, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    issue("rem_ovf", divop_rem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    issue("divu_by0", divop_divu, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 0);
    issue("rem_by0", divop_rem, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0);
    idle();

    issue("div_m7_2", divop_div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 4);
    issue("divu_m7_2", divop_divu, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 4);
    issue("rem_m7_2", divop_rem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 4);
    idle();

    // Back-to-back identical request right after completion hits.
    core_lat = 1;
    issue("divu_9_2", divop_divu, 32'd9, 32'd2, 32'd4, 2);
    issue("divu_9_2_hit", divop_divu, 32'd9, 32'd2, 32'd4, 0);
    idle();

    // Flush after two busy cycles.
    core_lat = 5;
    en = 1'b1; divop = divop_div; dn = 32'd1000; dd = 32'd3;
    repeat (3) begin @(posedge clk); #1; end
    en = 1'b0;
    @(negedge clk);
    chk("flush_div_en", 32'(div_en), 32'd0);
    @(posedge clk); #1;
    issue("div_1000_3", divop_div, 32'd1000, 32'd3, 32'd333, 6);
    idle();

    // Reset mid-busy invalidates the cache.
    core_lat = 3;
    issue("divu_50_5", divop_divu, 32'd50, 32'd5, 32'd10, 4);
    idle();
    en = 1'b1; divop = divop_remu; dn = 32'd50; dd = 32'd5;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_div_en", 32'(div_en), 32'd0);
    chk("post_rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    issue("divu_50_5_after_rst", divop_divu, 32'd50, 32'd5, 32'd10, 4);
    idle();

    // Constrained random run against the reference semantics.
    begin
      logic [31:0] n, d;
      rv32_divop   op;
      int          r;
      n = 32'd1; d = 32'd1;
      for (int i = 0; i < 30; i++) begin
        op = rv32_divop'($urandom_range(0, 3));
        r  = $urandom_range(0, 9);
        if (r == 0) begin
          n = $urandom; d = 32'd0;
        end else if (r == 1) begin
          op = $urandom_range(0, 1) ? divop_div : divop_rem;
          n = 32'h8000_0000; d = 32'hFFFF_FFFF;
        end else if (r >= 4) begin
          n = $urandom; d = $urandom >> $urandom_range(0, 30);
        end
        core_lat = $urandom_range(1, 4);
        issue("rand", op, n, d, golden(op, n, d), -1);
        if ($urandom_range(0, 1) == 1) idle();
      end
      idle();
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_dispatch.md
# div_dispatch

Front-end stage between the execute-stage M-extension decode and the iterative divider core. It takes RISC-V DIV/DIVU/REM/REMU requests and resolves divide-by-zero and signed overflow in zero cycles. It serves repeated operations from a one-entry result cache. All other requests are forwarded to the divider core with operands held stable in registers until the core finishes.

## Interface
- N, 32, data width; a power of 2, at least 4; must match the divider core
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  synchronous, active-high reset
- i_en  in  1  request valid; held high by the pipeline with stable operands until o_stall is low
- i_divop  in  rv32_divop  divop_div / divop_divu / divop_rem / divop_remu (from package types)
- i_data_n  in  N  dividend
- i_data_d  in  N  divisor
- o_data  out  N  result; valid when i_en=1 and o_stall=0
- o_stall  out  1  pipeline stall request
- o_div_en  out  1  divider core enable
- o_div_divop  out  rv32_divop  registered op to the core
- o_div_data_n  out  N  registered dividend to the core
- o_div_data_d  out  N  registered divisor to the core
- i_div_data  in  N  core result
- i_div_stall  in  1  core busy; the core result is valid in the first cycle of o_div_en=1 in which i_div_stall=0 after at least one busy cycle

## Operation
- signed = (op is div or rem); quotient-kind = (op is div or divu).
- Bypass is combinational and has priority over everything else. It applies when i_en=1 and one of these holds:
  - Zero divisor (d==0): quotient = all ones; remainder = n.
  - Signed overflow (signed, n==1<<(N-1), d==all ones): quotient = n; remainder = 0.
  - Cache hit: the cache is valid, its signed flag, n and d match the request, and the matching kind-valid bit is set. o_data comes from the cached quotient or remainder.
- During bypass: o_stall=0; the FSM stays in IDLE; the cache is not written.
- Cache contents: valid, signed, n, d, q_valid, q, r_valid, r.
  - On a core completion with the same signed/n/d as the current entry: set only the completed kind (q or r and its valid bit).
  - Otherwise: overwrite the whole entry and clear the other kind's valid bit.
- FSM states are IDLE and BUSY.
  - IDLE, i_en=1, no bypass: o_stall=1; latch op, n and d into the operand registers; go to BUSY.
  - BUSY, i_en=1: o_div_en=1 and o_stall=1, until the core result is valid.
  - BUSY, core result valid: o_stall=0; o_data=i_div_data; write the cache; go to IDLE.
  - BUSY, i_en=0 (flush): go to IDLE; o_div_en=0 the same cycle; the cache is not written.
- The operand registers update only on the IDLE to BUSY transition. o_div_* never change while in BUSY.
- If i_en stays high in the cycle after completion with identical operands and op, the request hits the cache. It does not restart the core.

## Timing
- Reset values: FSM=IDLE, cache valid and all kind-valid bits 0, operand registers 0, o_div_en=0, o_stall=0, o_data=0 whenever i_en=0.
- Bypass latency: 0 stall cycles; the result is available in the same cycle as i_en.
- Core path: o_stall high from the first i_en cycle through every core-busy cycle. Total stall = 1 + core busy cycles. o_stall falls in the completion cycle.
- o_stall and o_data are combinational from i_en, i_data_*, the cache and the FSM. o_div_* are registered, except o_div_en, which is decoded from the FSM state and i_en.
- Reset in BUSY: return to IDLE next edge; o_div_en=0; the cache is invalidated.
- i_rst has priority over i_en in the same cycle.
- i_en with i_rst: no capture; o_stall=0 the following cycle if i_en drops.

## Test plan
- DIVU 100/7 with a cold cache -> o_stall=1 for 1+core cycles, o_data=14. Then REMU 100/7 -> core run, o_data=2. Then DIVU 100/7 again -> 0-cycle hit, o_data=14.
- DIV 0x80000000 / 0xFFFFFFFF -> o_stall=0, o_data=0x80000000. REM with the same operands -> o_data=0. o_div_en stays 0 throughout.
- DIVU 0x1234 / 0 -> o_data=0xFFFFFFFF. REM 0xFFFFFFF9 / 0 -> o_data=0xFFFFFFF9. Both with 0 stall cycles.
- DIV -7/2 -> o_data=0xFFFFFFFD. Then DIVU 0xFFFFFFF9/2 (same bits, unsigned) -> miss, core run, o_data=0x7FFFFFFC.
- Start DIV 1000/3, drop i_en after 2 BUSY cycles -> o_div_en=0 next cycle. Then DIV 1000/3 -> full core run (no stale hit), o_data=333.
- Assert i_rst mid-BUSY -> IDLE, cache cleared. A repeat of the last completed op misses and runs the core.
- Random constrained run (all ops, N=32, 20% zero/overflow corners) against a golden model -> every o_data matches, o_div_* stable throughout BUSY.
